// File: rtl/mrv1_pkg.sv
// Shared definitions for the MRV1 issue stage.
package mrv1_pkg;

  // Per-thread issue state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } th_state_e;

endpackage : mrv1_pkg

// File: rtl/mrv1_issue_sched_if.sv
// Decode-to-issue handshake bundle for the multithreaded issue scheduler.
// The master side drives thread status and flushes; the slave side is the scheduler.
interface mrv1_issue_sched_if #(
  parameter int NUM_THREADS_P = 8,
  parameter int NUM_FU_P      = 4
);
  localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P);

  logic [NUM_THREADS_P-1:0]               th_en_i;
  logic [NUM_THREADS_P-1:0]               insn_vld_i;
  logic [NUM_THREADS_P-1:0]               iq_rdy_i;
  logic [NUM_THREADS_P-1:0]               rs_conflict_i;
  logic [NUM_THREADS_P-1:0][NUM_FU_P-1:0] fu_req_i;
  logic [NUM_FU_P-1:0]                    exec_fu_rdy_i;
  logic                                   flush_vld_i;
  logic [TID_WIDTH_LP-1:0]                flush_tid_i;

  logic                                   issue_vld_o;
  logic [TID_WIDTH_LP-1:0]                issue_tid_o;
  logic [NUM_THREADS_P-1:0]               deq_o;
  logic [NUM_THREADS_P-1:0]               th_busy_o;
  logic [31:0]                            issue_cnt_o;

  modport master (
    output th_en_i, insn_vld_i, iq_rdy_i, rs_conflict_i, fu_req_i,
           exec_fu_rdy_i, flush_vld_i, flush_tid_i,
    input  issue_vld_o, issue_tid_o, deq_o, th_busy_o, issue_cnt_o
  );

  modport slave (
    input  th_en_i, insn_vld_i, iq_rdy_i, rs_conflict_i, fu_req_i,
           exec_fu_rdy_i, flush_vld_i, flush_tid_i,
    output issue_vld_o, issue_tid_o, deq_o, th_busy_o, issue_cnt_o
  );

endinterface : mrv1_issue_sched_if

// File: rtl/mrv1_rr_arb.sv
// Rotating-priority arbiter: picks the first requester at or above ptr_i,
// wrapping past the top thread back to thread 0.
module mrv1_rr_arb #(
  parameter int NUM_THREADS_P = 8
) (
  input  logic [NUM_THREADS_P-1:0]         req_i,
  input  logic [$clog2(NUM_THREADS_P)-1:0] ptr_i,
  output logic [NUM_THREADS_P-1:0]         gnt_o,
  output logic [$clog2(NUM_THREADS_P)-1:0] gnt_tid_o,
  output logic                             gnt_vld_o
);
  localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P);

  logic [TID_WIDTH_LP-1:0] idx;

  // Walk the threads starting at ptr_i; the thread count is a power of two so
  // the index wraps by plain truncation.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    gnt_o     = '0;
    gnt_tid_o = '0;
    gnt_vld_o = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_THREADS_P; i++) begin
      idx = ptr_i + TID_WIDTH_LP'(i);
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_vld_o  = 1'b1;
        gnt_tid_o  = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule : mrv1_rr_arb

// File: rtl/mrv1_issue_sched.sv
// Multithreaded issue scheduler: one instruction per cycle from the eligible
// threads in round-robin order, with per-thread IDLE/RUN/FLUSH tracking.
module mrv1_issue_sched
  import mrv1_pkg::*;
#(
  parameter int NUM_THREADS_P  = 8,
  parameter int NUM_FU_P       = 4,
  parameter int FLUSH_CYCLES_P = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mrv1_issue_sched_if.slave bus
);
  localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P);
  localparam int CNT_WIDTH_LP = $clog2(FLUSH_CYCLES_P + 1);

  th_state_e               state_q [NUM_THREADS_P];
  th_state_e               state_d [NUM_THREADS_P];
  logic [CNT_WIDTH_LP-1:0] cnt_q   [NUM_THREADS_P];
  logic [CNT_WIDTH_LP-1:0] cnt_d   [NUM_THREADS_P];

  logic [TID_WIDTH_LP-1:0]  rr_ptr_q, rr_ptr_d;
  logic [TID_WIDTH_LP-1:0]  last_tid_q, last_tid_d;
  logic [31:0]              issue_cnt_q, issue_cnt_d;

  logic [NUM_THREADS_P-1:0] elig;
  logic [NUM_THREADS_P-1:0] gnt;
  logic [TID_WIDTH_LP-1:0]  gnt_tid;
  logic                     gnt_vld;

  // A thread may issue when running, its head is ready, an FU it wants is
  // free, and it is not being flushed this very cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_THREADS_P; i++) begin
      elig[i] = (state_q[i] == RUN)
              & bus.insn_vld_i[i]
              & bus.iq_rdy_i[i]
              & ~bus.rs_conflict_i[i]
              & (|(bus.fu_req_i[i] & bus.exec_fu_rdy_i))
              & ~(bus.flush_vld_i && (bus.flush_tid_i == TID_WIDTH_LP'(i)));
    end
  end

  mrv1_rr_arb #(
    .NUM_THREADS_P (NUM_THREADS_P)
  ) u_rr_arb (
    .req_i     (elig),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_tid_o (gnt_tid),
    .gnt_vld_o (gnt_vld)
  );

  assign bus.issue_vld_o = gnt_vld;
  assign bus.deq_o       = gnt;
  assign bus.issue_tid_o = gnt_vld ? gnt_tid : last_tid_q;
  assign bus.issue_cnt_o = issue_cnt_q;

  // Busy flags mirror the FLUSH state of each thread.
  always_comb begin
    bus.th_busy_o = '0;
    for (int i = 0; i < NUM_THREADS_P; i++) begin
      bus.th_busy_o[i] = (state_q[i] == FLUSH);
    end
  end

  // Per-thread next state; a flush outranks enable changes and restarts the
  // blocking window even if one is already running.
  always_comb begin
    for (int i = 0; i < NUM_THREADS_P; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (bus.th_en_i[i]) state_d[i] = RUN;
        end
        RUN: begin
          if (bus.flush_vld_i && (bus.flush_tid_i == TID_WIDTH_LP'(i))) begin
            state_d[i] = FLUSH;
            cnt_d[i]   = CNT_WIDTH_LP'(FLUSH_CYCLES_P);
          end else if (!bus.th_en_i[i]) begin
            state_d[i] = IDLE;
          end
        end
        FLUSH: begin
          if (bus.flush_vld_i && (bus.flush_tid_i == TID_WIDTH_LP'(i))) begin
            cnt_d[i] = CNT_WIDTH_LP'(FLUSH_CYCLES_P);
          end else if (cnt_q[i] == CNT_WIDTH_LP'(1)) begin
            state_d[i] = bus.th_en_i[i] ? RUN : IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_WIDTH_LP'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Round-robin pointer, last granted thread and issue counter advance on a grant.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    last_tid_d  = last_tid_q;
    issue_cnt_d = issue_cnt_q;
    if (gnt_vld) begin
      rr_ptr_d    = gnt_tid + TID_WIDTH_LP'(1);
      last_tid_d  = gnt_tid;
      issue_cnt_d = issue_cnt_q + 32'd1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: the per-thread arrays are control state, not data storage, so
      // every element is reset; a thread must never wake up in RUN or FLUSH.
      for (int i = 0; i < NUM_THREADS_P; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      rr_ptr_q    <= '0;
      last_tid_q  <= '0;
      issue_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      for (int i = 0; i < NUM_THREADS_P; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      last_tid_q  <= last_tid_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

endmodule : mrv1_issue_sched

// File: tb/tb_mrv1_issue_sched.sv
// Self-checking bench for mrv1_issue_sched: directed scenarios followed by
// random traffic, all compared against a thread-level reference model.
module tb_mrv1_issue_sched;
  localparam int NT = 8;
  localparam int NF = 4;
  localparam int FC = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  mrv1_issue_sched_if #(.NUM_THREADS_P(NT), .NUM_FU_P(NF)) bus ();

  mrv1_issue_sched #(
    .NUM_THREADS_P  (NT),
    .NUM_FU_P       (NF),
    .FLUSH_CYCLES_P (FC)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: a thread is running, idle, or blocked for m_fl more cycles.
  bit          m_run [NT];
  int          m_fl  [NT];
  int          m_rr;
  int          m_last;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_run[i] = 1'b0;
      m_fl[i]  = 0;
    end
    m_rr   = 0;
    m_last = 0;
    m_cnt  = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_vld",  32'(bus.issue_vld_o), 32'd0);
    check("rst_tid",  32'(bus.issue_tid_o), 32'd0);
    check("rst_deq",  32'(bus.deq_o),       32'd0);
    check("rst_busy", 32'(bus.th_busy_o),   32'd0);
    check("rst_cnt",  bus.issue_cnt_o,      32'd0);
  endtask

  // Assert reset asynchronously (away from the clock edge), check, then release.
  task automatic do_reset();
    rst_i = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Compare DUT outputs against the model for the current inputs, then
  // advance the model to the next cycle.
  task automatic sample();
    bit              any;
    int              g;
    int              t;
    bit              hit;
    logic [NT-1:0]   elig;
    logic [NT-1:0]   exp_deq;
    logic [NT-1:0]   exp_busy;
    @(negedge clk_i);
    for (int i = 0; i < NT; i++) begin
      elig[i] = m_run[i] && (m_fl[i] == 0) && bus.insn_vld_i[i] && bus.iq_rdy_i[i]
                && !bus.rs_conflict_i[i] && ((bus.fu_req_i[i] & bus.exec_fu_rdy_i) != '0)
                && !(bus.flush_vld_i && (int'(bus.flush_tid_i) == i));
      exp_busy[i] = (m_fl[i] > 0);
    end
    any = 1'b0;
    g   = 0;
    for (int k = 0; k < NT; k++) begin
      t = (m_rr + k) % NT;
      if (!any && elig[t]) begin
        any = 1'b1;
        g   = t;
      end
    end
    exp_deq = '0;
    if (any) exp_deq[g] = 1'b1;
    check("vld",  32'(bus.issue_vld_o), 32'(any));
    check("tid",  32'(bus.issue_tid_o), any ? 32'(g) : 32'(m_last));
    check("deq",  32'(bus.deq_o),       32'(exp_deq));
    check("busy", 32'(bus.th_busy_o),   32'(exp_busy));
    check("cnt",  bus.issue_cnt_o,      m_cnt);
    if (any) begin
      m_rr   = (g + 1) % NT;
      m_last = g;
      m_cnt  = m_cnt + 32'd1;
    end
    for (int i = 0; i < NT; i++) begin
      hit = bus.flush_vld_i && (int'(bus.flush_tid_i) == i);
      if (m_fl[i] > 0) begin
        if (hit)              m_fl[i] = FC;
        else if (m_fl[i] == 1) begin
          m_fl[i]  = 0;
          m_run[i] = bus.th_en_i[i];
        end else              m_fl[i] = m_fl[i] - 1;
      end else if (m_run[i]) begin
        if (hit) begin
          m_fl[i]  = FC;
          m_run[i] = 1'b0;
        end else m_run[i] = bus.th_en_i[i];
      end else begin
        m_run[i] = bus.th_en_i[i];
      end
    end
  endtask

  task automatic set_common(input logic [NT-1:0] vld);
    bus.th_en_i       = '1;
    bus.insn_vld_i    = vld;
    bus.iq_rdy_i      = '1;
    bus.rs_conflict_i = '0;
    for (int i = 0; i < NT; i++) bus.fu_req_i[i] = 4'b0001;
    bus.exec_fu_rdy_i = '1;
    bus.flush_vld_i   = 1'b0;
    bus.flush_tid_i   = '0;
  endtask

  initial begin
    bus.th_en_i       = '0;
    bus.insn_vld_i    = '0;
    bus.iq_rdy_i      = '0;
    bus.rs_conflict_i = '0;
    bus.fu_req_i      = '0;
    bus.exec_fu_rdy_i = '0;
    bus.flush_vld_i   = 1'b0;
    bus.flush_tid_i   = '0;
    #2;
    do_reset();

    // All threads enabled and eligible: nothing in the first cycle, then 0..7 twice.
    set_common('1);
    sample();
    check("first_cycle_idle", 32'(bus.issue_vld_o), 32'd0);
    tick();
    for (int k = 0; k < 16; k++) begin
      sample();
      check("rr_order", 32'(bus.issue_tid_o), 32'(k % NT));
      tick();
    end

    // Move the pointer to 6 by granting thread 5 alone.
    set_common(8'b0010_0000);
    sample();
    check("cnt_after_16", bus.issue_cnt_o, 32'd16);
    check("grant5", 32'(bus.issue_tid_o), 32'd5);
    tick();

    // Only threads 2 and 7: 7 first, then wrap to 2.
    set_common(8'b1000_0100);
    sample();
    check("wrap_first", 32'(bus.issue_tid_o), 32'd7);
    tick();
    sample();
    check("wrap_second", 32'(bus.issue_tid_o), 32'd2);
    tick();

    // Flush thread 3 in the cycle it is the sole eligible thread.
    set_common(8'b0000_1000);
    bus.flush_vld_i = 1'b1;
    bus.flush_tid_i = 3'd3;
    sample();
    check("flush_suppress", 32'(bus.issue_vld_o), 32'd0);
    tick();
    bus.flush_vld_i = 1'b0;
    for (int k = 0; k < FC; k++) begin
      sample();
      check("flush_busy", 32'(bus.th_busy_o[3]), 32'd1);
      tick();
    end
    sample();
    check("flush_regrant", 32'(bus.deq_o), 32'h08);
    tick();

    // FU mismatch blocks thread 1 until its FU becomes ready.
    set_common(8'b0000_0010);
    bus.fu_req_i[1]   = 4'b0010;
    bus.exec_fu_rdy_i = 4'b1101;
    sample();
    check("fu_blocked", 32'(bus.issue_vld_o), 32'd0);
    tick();
    bus.exec_fu_rdy_i = 4'b1111;
    sample();
    check("fu_ready", 32'(bus.deq_o), 32'h02);
    tick();

    // Reset in the middle of a flush window with five instructions counted.
    do_reset();
    set_common(8'b0000_0001);
    sample();
    tick();
    for (int k = 0; k < 5; k++) begin
      sample();
      tick();
    end
    bus.flush_vld_i = 1'b1;
    bus.flush_tid_i = 3'd0;
    sample();
    tick();
    bus.flush_vld_i = 1'b0;
    check("pre_rst_cnt",  bus.issue_cnt_o,        32'd5);
    check("pre_rst_busy", 32'(bus.th_busy_o[0]),  32'd1);
    do_reset();
    sample();
    check("post_rst_idle", 32'(bus.issue_vld_o), 32'd0);
    tick();
    sample();
    check("post_rst_grant", 32'(bus.deq_o), 32'h01);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NT; i++) begin
        bus.th_en_i[i]       = ($urandom_range(0, 7) != 0);
        bus.insn_vld_i[i]    = ($urandom_range(0, 3) != 0);
        bus.iq_rdy_i[i]      = ($urandom_range(0, 5) != 0);
        bus.rs_conflict_i[i] = ($urandom_range(0, 5) == 0);
        bus.fu_req_i[i]      = 4'(1 << $urandom_range(0, NF - 1));
      end
      bus.exec_fu_rdy_i = 4'($urandom_range(0, 15));
      bus.flush_vld_i   = ($urandom_range(0, 5) == 0);
      bus.flush_tid_i   = 3'($urandom_range(0, NT - 1));
      sample();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mrv1_issue_sched
